// File: rtl/array_cond_add_pkg.sv
// Shared constants and state encoding for the conditional-add stage of modular halving.
package array_cond_add_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
    localparam int unsigned DEFAULT_TOTAL_WORDS = 64;
    localparam int unsigned DEFAULT_ADDR_WIDTH  = 32;
    localparam int unsigned READ_LATENCY        = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } cond_add_state_e;

endpackage

// File: rtl/array_cond_add_adder.sv
// Registered word adder with carry-in/carry-out; cout_next exposes the carry being captured.
module word_adder_cin #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  cout_next
);

    logic [DATA_WIDTH:0] full;

    assign full      = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};
    assign cout_next = full[DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (en) begin
            sum  <= full[DATA_WIDTH-1:0];
            cout <= full[DATA_WIDTH];
        end
    end

endmodule

// File: rtl/array_cond_add.sv
// Conditional add of N to a multiword operand when word 0 is odd (x + N*odd(x)), LSW first.
// Optional add_odd output enabled by defining COND_ADD_ODD_FLAG_EN.
module array_cond_add
    import array_cond_add_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned TOTAL_WORDS = DEFAULT_TOTAL_WORDS,
    parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  add_start,
    output logic                  read_en,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] m_temp,
    input  logic [DATA_WIDTH-1:0] n_word,
    output logic                  add_valid,
    output logic [ADDR_WIDTH-1:0] add_addr,
    output logic [DATA_WIDTH-1:0] add_sum,
    output logic                  add_carry,
    output logic                  add_ok
`ifdef COND_ADD_ODD_FLAG_EN
    ,
    output logic                  add_odd
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_WORDS - 1);

    cond_add_state_e state;
    logic            drain_cnt;

    // Stage 1: read issued last cycle, data present on m_temp/n_word now.
    logic                  rd_vld_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    logic                  odd_q;
    logic                  first_word;
    logic                  last_word;
    logic                  odd_eff;
    logic                  cin;
    logic [DATA_WIDTH-1:0] addend;
    logic                  carry_q;
    logic                  carry_next;
    logic                  start_acc;

    assign start_acc  = (state == StIdle) && add_start;
    assign first_word = rd_vld_q && (rd_addr_q == '0);
    assign last_word  = rd_vld_q && (rd_addr_q == LAST_ADDR);

    // Word 0 decides oddness combinationally; later words use the registered decision.
    assign odd_eff = first_word ? m_temp[0] : odd_q;
    assign cin     = first_word ? 1'b0 : carry_q;
    assign addend  = odd_eff ? n_word : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= StIdle;
            read_en   <= 1'b0;
            read_addr <= '0;
            drain_cnt <= 1'b0;
            add_ok    <= 1'b0;
        end else begin
            add_ok <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (add_start) begin
                        state     <= StRead;
                        read_en   <= 1'b1;
                        read_addr <= '0;
                    end
                end
                StRead: begin
                    if (read_addr == LAST_ADDR) begin
                        state     <= StDrain;
                        read_en   <= 1'b0;
                        read_addr <= '0;
                        drain_cnt <= 1'b0;
                    end else begin
                        read_addr <= read_addr + 1'b1;
                    end
                end
                StDrain: begin
                    if (drain_cnt) begin
                        state  <= StDone;
                        add_ok <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            add_valid <= 1'b0;
            add_addr  <= '0;
        end else begin
            rd_vld_q  <= read_en;
            rd_addr_q <= read_addr;
            add_valid <= rd_vld_q;
            add_addr  <= rd_addr_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            odd_q     <= 1'b0;
            add_carry <= 1'b0;
        end else if (start_acc) begin
            odd_q     <= 1'b0;
            add_carry <= 1'b0;
        end else begin
            if (first_word) begin
                odd_q <= m_temp[0];
            end
            if (last_word) begin
                add_carry <= carry_next;
            end
        end
    end

    word_adder_cin #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_adder (
        .clk      (CLK),
        .rst      (RST),
        .en       (rd_vld_q),
        .a        (m_temp),
        .b        (addend),
        .cin      (cin),
        .sum      (add_sum),
        .cout     (carry_q),
        .cout_next(carry_next)
    );

`ifdef COND_ADD_ODD_FLAG_EN
    assign add_odd = odd_q;
`endif

endmodule

// File: tb/tb_array_cond_add.sv
// Directed self-checking bench for array_cond_add with 8-bit words and 4-word operands.
module tb_array_cond_add;

    localparam int unsigned DW = 8;
    localparam int unsigned TW = 4;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          add_start;
    logic          read_en;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] m_temp;
    logic [DW-1:0] n_word;
    logic          add_valid;
    logic [AW-1:0] add_addr;
    logic [DW-1:0] add_sum;
    logic          add_carry;
    logic          add_ok;
`ifdef COND_ADD_ODD_FLAG_EN
    logic          add_odd;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] a_mem [TW];
    logic [DW-1:0] n_mem [TW];

    always #5 clk = ~clk;

    array_cond_add #(
        .DATA_WIDTH (DW),
        .TOTAL_WORDS(TW),
        .ADDR_WIDTH (AW)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .add_start(add_start),
        .read_en  (read_en),
        .read_addr(read_addr),
        .m_temp   (m_temp),
        .n_word   (n_word),
        .add_valid(add_valid),
        .add_addr (add_addr),
        .add_sum  (add_sum),
        .add_carry(add_carry),
        .add_ok   (add_ok)
`ifdef COND_ADD_ODD_FLAG_EN
        ,
        .add_odd  (add_odd)
`endif
    );

    // Word memories with one cycle of read latency.
    always @(posedge clk) begin
        if (read_en) begin
            m_temp <= a_mem[read_addr[1:0]];
            n_word <= n_mem[read_addr[1:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_read_en"}, 32'(read_en), 32'd0);
        check_eq({tag, "_read_addr"}, read_addr, 32'd0);
        check_eq({tag, "_add_valid"}, 32'(add_valid), 32'd0);
        check_eq({tag, "_add_addr"}, add_addr, 32'd0);
        check_eq({tag, "_add_sum"}, 32'(add_sum), 32'd0);
        check_eq({tag, "_add_carry"}, 32'(add_carry), 32'd0);
        check_eq({tag, "_add_ok"}, 32'(add_ok), 32'd0);
    endtask

    // Runs idle cycles and requires that no output word or completion pulse appears.
    task automatic idle_check(input string tag, input int cycles);
        int activity = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (add_valid || add_ok) activity++;
        end
        check_eq({tag, "_idle_activity"}, 32'(activity), 32'd0);
    endtask

    // Vectors packed LSW in bits [7:0]. Returns at the negedge of the add_ok cycle.
    task automatic run_pass(input string tag, input logic [31:0] a_vec, input logic [31:0] n_vec,
                            input logic [31:0] sums_exp, input logic carry_exp,
                            input logic odd_exp, input bit busy);
        logic [DW-1:0] got_sum [TW];
        int  nv     = 0;
        int  ok_cyc = 0;
        bit  done   = 1'b0;
        logic [31:0] sums_vec;
        for (int i = 0; i < int'(TW); i++) begin
            a_mem[i]   = a_vec[8*i +: 8];
            n_mem[i]   = n_vec[8*i +: 8];
            got_sum[i] = 'x;
        end
        @(negedge clk);
        add_start = 1'b1;
        @(negedge clk);
        add_start = 1'b0;
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            if (cyc == 1) check_eq({tag, "_carry_clr"}, 32'(add_carry), 32'd0);
            if (cyc <= int'(TW)) begin
                check_eq({tag, "_read_en"}, 32'(read_en), 32'd1);
                check_eq({tag, "_read_addr"}, read_addr, 32'(cyc - 1));
            end else if (cyc == int'(TW) + 1) begin
                check_eq({tag, "_read_en_off"}, 32'(read_en), 32'd0);
            end
            if (add_valid) begin
                check_eq({tag, "_add_addr"}, add_addr, 32'(nv));
                check_eq({tag, "_valid_cycle"}, 32'(cyc), 32'(nv + 3));
                if (nv < int'(TW)) got_sum[nv] = add_sum;
                nv++;
            end
            if (add_ok) begin
                ok_cyc = cyc;
                done   = 1'b1;
            end else begin
                add_start = busy && (cyc == 2);
                @(negedge clk);
            end
        end
        add_start = 1'b0;
        check_eq({tag, "_word_count"}, 32'(nv), 32'(TW));
        check_eq({tag, "_ok_cycle"}, 32'(ok_cyc), 32'(TW + 3));
        sums_vec = sums_exp;
        for (int i = 0; i < int'(TW); i++) begin
            check_eq({tag, "_sum"}, 32'(got_sum[i]), 32'(sums_vec[8*i +: 8]));
        end
        check_eq({tag, "_carry"}, 32'(add_carry), 32'(carry_exp));
`ifdef COND_ADD_ODD_FLAG_EN
        check_eq({tag, "_odd"}, 32'(add_odd), 32'(odd_exp));
`else
        if (odd_exp === 1'bx) $display("odd flag unknown");
`endif
    endtask

    initial begin
        rst       = 1'b1;
        add_start = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        run_pass("even", 32'h00000010, 32'h000001FF, 32'h00000010, 1'b0, 1'b0, 1'b0);
        run_pass("odd_ripple", 32'h0000FF01, 32'h000001FF, 32'h00010100, 1'b0, 1'b1, 1'b0);
        run_pass("overflow", 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("overflow_carry_held", 32'(add_carry), 32'd1);

        run_pass("busy", 32'h55443322, 32'h11111111, 32'h55443322, 1'b0, 1'b0, 1'b1);
        idle_check("busy", 10);

        // Abort in the second READ cycle.
        a_mem[0] = 8'h03;
        @(negedge clk);
        add_start = 1'b1;
        @(negedge clk);
        add_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("abort");
        rst = 1'b0;
        idle_check("abort", 10);
        run_pass("after_abort", 32'h0000FF01, 32'h000001FF, 32'h00010100, 1'b0, 1'b1, 1'b0);

        run_pass("b2b_first", 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0);
        run_pass("b2b_second", 32'h05040302, 32'h01010101, 32'h05040302, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/array_cond_add.md
Name: array_cond_add

Overview:
- Upstream neighbour of the array right-shift stage in the RSA core; together they implement modular halving, x/2 mod N = (x + N·odd(x)) >> 1.
- Streams a multiword operand and the modulus N out of word memories, least-significant word first.
- If word 0 of the operand is odd, adds N with ripple carry across words; otherwise passes the operand through.
- Emits a word stream (valid/addr/data) plus a final carry that the shift stage consumes as its top bit.

Parameters:
- DATA_WIDTH, 32, word width in bits (matches the core-wide data width).
- TOTAL_WORDS, 64, words per operand array (2 × core TOTAL_ADDR); must be ≥ 2.
- ADDR_WIDTH, 32, width of the address ports.

Ports:
- CLK  in  1  core clock.
- RST  in  1  synchronous, active-high reset.
- add_start  in  1  one-cycle start pulse; honoured only in IDLE.
- read_en  out  1  memory read strobe for both arrays.
- read_addr  out  ADDR_WIDTH  word address, shared by both arrays.
- m_temp  in  DATA_WIDTH  operand word; valid exactly 1 cycle after its read_en/read_addr.
- n_word  in  DATA_WIDTH  modulus word; same timing as m_temp.
- add_valid  out  1  output word valid.
- add_addr  out  ADDR_WIDTH  index of the output word.
- add_sum  out  DATA_WIDTH  output word.
- add_carry  out  1  carry out of the most-significant word; valid with the last word and held until the next start.
- add_ok  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE. All outputs 0: read_en, read_addr, add_valid, add_addr, add_sum, add_carry, add_ok. Internal carry and odd registers 0. Reset during an operation aborts it; no add_ok is produced.
- State machine, states IDLE, READ, DRAIN, DONE:
  - IDLE → READ when add_start=1. add_carry is cleared on this edge.
  - READ: read_en=1; read_addr steps 0..TOTAL_WORDS-1, one word per cycle. After the cycle that issues address TOTAL_WORDS-1, go to DRAIN.
  - DRAIN: 2 cycles; read_en=0 and read_addr=0.
  - DONE: add_ok=1 for 1 cycle, then IDLE.
  - add_start outside IDLE is ignored.
- Pipeline: a read issued in cycle t returns data in t+1; the registered output appears in t+2.
  - add_valid is read_en delayed by 2 cycles.
  - add_addr is the read address delayed by 2 cycles.
- Odd decision:
  - When the data word for address 0 arrives, odd = m_temp[0] (combinational use).
  - odd is also registered and applied to every later word of the same pass.
- Arithmetic per word, width DATA_WIDTH+1:
  - sum = m_temp + (odd ? n_word : 0) + cin.
  - cin is 0 for word 0; for later words it is the carry out of the previous word.
  - add_sum = sum[DATA_WIDTH-1:0].
  - The carry out of the last word is registered into add_carry on the same edge the last add_sum is registered.
- Even case: add_sum equals m_temp exactly and add_carry=0.
- Timing: start sampled in c0 → add_valid in c3..c(TOTAL_WORDS+2) → add_ok in c(TOTAL_WORDS+3).
- Inputs are treated as unsigned; a signed interpretation is the downstream stage's concern.

Optional Feature:
- Macro COND_ADD_ODD_FLAG_EN.
- Defined: adds output port add_odd (1 bit). It carries the registered odd decision, is valid from the first add_valid until the next add_start, resets to 0, and lets the controller count reductions.
- Undefined: the port and its register are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include holds DATA_WIDTH, TOTAL_WORDS, the state encodings (IDLE=0, READ=1, DRAIN=2, DONE=3) and the read-latency constant (1).
- One natural sub-module, word_adder_cin: a registered DATA_WIDTH adder with carry-in/carry-out and an enable. The top level keeps the FSM, address counter, valid/address delay line and odd register.

Test Plan (DATA_WIDTH=8, TOTAL_WORDS=4, words listed LSW first):
- Even pass: A=[10,00,00,00], N=[FF,01,00,00] → add_sum stream 10,00,00,00 at add_addr 0..3; add_carry=0; add_ok 7 cycles after start.
- Odd with carry ripple: A=[01,FF,00,00], N=[FF,01,00,00] → sums 00,01,01,00; add_carry=0.
- Overflow: A=[FF,FF,FF,FF], N=[01,00,00,00] → sums 00,00,00,00; add_carry=1, held after add_ok until the next start.
- Busy start: second add_start pulse during READ → ignored; exactly one 4-word burst and one add_ok.
- Reset mid-op: RST high during the 2nd READ cycle → next cycle all outputs 0 and state IDLE; no add_ok. A following add_start runs a clean pass.
- Back-to-back: add_start in the cycle after add_ok, with even data following odd data → second pass uses its own odd flag (0), cin starts at 0, add_carry is cleared at start.
